wb_test_master: RTL and testbench



---
 rtl/wb_test_master.sv | 174 +++++++++++++++++
 tb/tb_wb_test_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_test_master.sv
// rtl/wb_test_master.sv - single-outstanding Wishbone classic initiator with cycle timeout
//
// Turns one valid/ready command into one Wishbone classic cycle. The cycle is
// abandoned when stb has been held TIMEOUT cycles without ack. The read data,
// or an error for a timeout, is returned on a valid/ready response port.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/adr/dat/sel          command payload (write flag, byte address, data, selects)
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes and errors), timeout flag
//   wbm_*                       Wishbone classic master signals
//   txn_count                   completed transactions, wraps
//   err_count                   timeouts, saturates at 255
module wb_test_master #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [15:0] txn_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Timer value seen at the edge where stb has been high for TIMEOUT cycles.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;

    logic          cmd_ready_n;
    logic          rsp_valid_n;
    logic [31:0]   rsp_dat_n;
    logic          rsp_err_n;
    logic          cyc_n;
    logic          stb_n;
    logic          we_n;
    logic [3:0]    sel_n;
    logic [31:0]   adr_n;
    logic [31:0]   dat_n;
    logic [15:0]   txn_count_n;
    logic [7:0]    err_count_n;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_dat   <= rsp_dat_n;
            rsp_err   <= rsp_err_n;
            wbm_cyc_o <= cyc_n;
            wbm_stb_o <= stb_n;
            wbm_we_o  <= we_n;
            wbm_sel_o <= sel_n;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
            txn_count <= txn_count_n;
            err_count <= err_count_n;
        end
    end

    // Next-state and next-output logic; every output is registered above so
    // nothing here reaches a port combinationally.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        cmd_ready_n = cmd_ready;
        rsp_valid_n = rsp_valid;
        rsp_dat_n   = rsp_dat;
        rsp_err_n   = rsp_err;
        cyc_n       = wbm_cyc_o;
        stb_n       = wbm_stb_o;
        we_n        = wbm_we_o;
        sel_n       = wbm_sel_o;
        adr_n       = wbm_adr_o;
        dat_n       = wbm_dat_o;
        txn_count_n = txn_count;
        err_count_n = err_count;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_n        = cmd_we;
                    adr_n       = cmd_adr;
                    dat_n       = cmd_dat;
                    sel_n       = cmd_sel;
                    cyc_n       = 1'b1;
                    stb_n       = 1'b1;
                    timer_n     = '0;
                    cmd_ready_n = 1'b0;
                    state_n     = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the last allowed cycle
                // completes normally instead of counting as a timeout.
                if (wbm_ack_i) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_dat_n   = wbm_we_o ? 32'd0 : wbm_dat_i;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    txn_count_n = txn_count + 16'd1;
                    state_n     = RESP;
                end else if (timer == TIMER_LAST) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_dat_n   = 32'd0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    txn_count_n = txn_count + 16'd1;
                    if (err_count != 8'hFF) begin
                        err_count_n = err_count + 8'd1;
                    end
                    state_n     = RESP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_test_master.sv
// tb/tb_wb_test_master.sv - directed self-checking bench for wb_test_master
module tb_wb_test_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    wb_test_master #(.TIMEOUT(4), .TW(8)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .txn_count(txn_count),
        .err_count(err_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Present a command and wait (bounded) for the handshake edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        int n;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Act as responder: ack in stb cycle wait_n+1 (never if wait_n < 0).
    // Counts stb cycles and flags any bus field that moved during the cycle.
    task automatic run_bus(input int wait_n, input logic [31:0] rdata,
                           output int stb_cycles, output logic stable);
        int n;
        stb_cycles = 0;
        stable     = 1'b1;
        wbm_dat_i  = rdata;
        n = 0;
        while (wbm_stb_o && n < 50) begin
            stb_cycles++;
            if (wbm_adr_o !== cmd_adr || wbm_dat_o !== cmd_dat ||
                wbm_sel_o !== cmd_sel || wbm_we_o !== cmd_we || wbm_cyc_o !== 1'b1)
                stable = 1'b0;
            wbm_ack_i = (wait_n >= 0) && (stb_cycles == wait_n + 1);
            step();
            n++;
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    int          cyc_cnt;
    logic        stab;
    logic [31:0] hold_dat;
    logic        hold_err;
    logic        hold_ok;

    initial begin
        step();
        step();
        wb_rst_i = 1'b0;
        step();

        // Reset state
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cyc_stb",   {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("rst_adr",       wbm_adr_o, 32'd0);
        check("rst_counts",    {8'd0, txn_count, err_count}, 32'd0);

        // Write, two wait cycles
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        check("wr_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        run_bus(2, 32'hDEAD_BEEF, cyc_cnt, stab);
        check("wr_stb_cycles", cyc_cnt, 32'd3);
        check("wr_bus_stable", {31'd0, stab}, 32'd1);
        check("wr_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_err",    {31'd0, rsp_err}, 32'd0);
        check("wr_rsp_dat",    rsp_dat, 32'd0);
        check("wr_txn_count",  {16'd0, txn_count}, 32'd1);
        check("wr_adr_kept",   wbm_adr_o, 32'h3000_0004);
        take_rsp();
        check("wr_rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        check("wr_cmd_ready",   {31'd0, cmd_ready}, 32'd1);

        // Read, zero-wait
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        run_bus(0, 32'hCAFE_F00D, cyc_cnt, stab);
        check("rd_stb_cycles", cyc_cnt, 32'd1);
        check("rd_bus_stable", {31'd0, stab}, 32'd1);
        check("rd_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        check("rd_rsp_dat",    rsp_dat, 32'hCAFE_F00D);
        check("rd_rsp_err",    {31'd0, rsp_err}, 32'd0);
        check("rd_txn_count",  {16'd0, txn_count}, 32'd2);
        take_rsp();

        // Timeout, no ack
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        run_bus(-1, 32'h1234_5678, cyc_cnt, stab);
        check("to_stb_cycles", cyc_cnt, 32'd4);
        check("to_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        check("to_rsp_err",    {31'd0, rsp_err}, 32'd1);
        check("to_rsp_dat",    rsp_dat, 32'd0);
        check("to_err_count",  {24'd0, err_count}, 32'd1);
        check("to_txn_count",  {16'd0, txn_count}, 32'd3);
        take_rsp();

        // Ack in the last allowed cycle beats the timeout
        issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        run_bus(3, 32'h1111_2222, cyc_cnt, stab);
        check("late_stb_cycles", cyc_cnt, 32'd4);
        check("late_rsp_err",    {31'd0, rsp_err}, 32'd0);
        check("late_rsp_dat",    rsp_dat, 32'h1111_2222);
        check("late_err_count",  {24'd0, err_count}, 32'd1);
        check("late_txn_count",  {16'd0, txn_count}, 32'd4);
        take_rsp();

        // Response backpressure
        issue(1'b0, 32'h3000_0028, 32'h0, 4'hF);
        run_bus(1, 32'h0BAD_F00D, cyc_cnt, stab);
        hold_dat = rsp_dat;
        hold_err = rsp_err;
        hold_ok  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = 32'h5555_AAAA;
            if (rsp_valid !== 1'b1 || rsp_dat !== hold_dat || rsp_err !== hold_err ||
                cmd_ready !== 1'b0 || wbm_stb_o !== 1'b0)
                hold_ok = 1'b0;
            step();
        end
        wbm_ack_i = 1'b0;
        check("bp_hold_stable", {31'd0, hold_ok}, 32'd1);
        check("bp_rsp_dat",     rsp_dat, 32'h0BAD_F00D);
        check("bp_txn_count",   {16'd0, txn_count}, 32'd5);
        take_rsp();
        check("bp_cmd_ready",   {31'd0, cmd_ready}, 32'd1);
        check("bp_rsp_cleared", {31'd0, rsp_valid}, 32'd0);

        // Reset in the second BUS cycle
        issue(1'b1, 32'h3000_0030, 32'h7777_8888, 4'h1);
        check("mr_stb_first", {31'd0, wbm_stb_o}, 32'd1);
        step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        check("mr_cyc_stb",   {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_counts",    {8'd0, txn_count, err_count}, 32'd0);
        check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        step();
        check("mr_no_rsp",    {31'd0, rsp_valid}, 32'd0);

        // 300 timeouts: err_count saturates, txn_count keeps counting
        for (int k = 0; k < 300; k++) begin
            issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
            run_bus(-1, 32'h0, cyc_cnt, stab);
            take_rsp();
            if (k == 254) check("sat_err_255", {24'd0, err_count}, 32'd255);
            if (k == 255) check("sat_txn_256", {16'd0, txn_count}, 32'd256);
        end
        check("sat_err_count", {24'd0, err_count}, 32'd255);
        check("sat_txn_count", {16'd0, txn_count}, 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
